// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - bus bundle between fetch_stage, instruction memory and controller
// Signals:
//   imem_addr/imem_req      fetch stage -> memory, fetch address and request
//   imem_rdata/imem_valid   memory -> fetch stage, instruction word and completion
//   pccontrol/flush/target/boffset/stall  controller -> fetch stage, next-PC steering
//   instr/instr_valid/pc_out/halted       fetch stage -> controller
// Modports: master = fetch stage view, slave = memory/controller view.
interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_req;
  logic [7:0]          imem_rdata;
  logic                imem_valid;
  logic [2:0]          pccontrol;
  logic                flush;
  logic [PC_WIDTH-1:0] target;
  logic [7:0]          boffset;
  logic                stall;
  logic [7:0]          instr;
  logic                instr_valid;
  logic [PC_WIDTH-1:0] pc_out;
  logic                halted;

  modport master (
    output imem_addr, imem_req, instr, instr_valid, pc_out, halted,
    input  imem_rdata, imem_valid, pccontrol, flush, target, boffset, stall
  );

  modport slave (
    input  imem_addr, imem_req, instr, instr_valid, pc_out, halted,
    output imem_rdata, imem_valid, pccontrol, flush, target, boffset, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one outstanding imem transaction
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      fetch_stage_if.master (imem handshake, controller steering, instruction out)
// Optional feature: define FETCH_STAGE_PC_RAS_EN to build a RAS_DEPTH-entry
// return-address stack used by pccontrol 011 (call) and 100 (return).
module fetch_stage #(
  parameter int unsigned         PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [7:0]          NOP_INSTR = 8'h00,
  parameter int unsigned         RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [PC_WIDTH-1:0] r_pc_out, w_pc_out_nxt;
  logic [PC_WIDTH-1:0] r_redirect_pc, w_redirect_nxt;
  logic [7:0]          r_instr, w_instr_nxt;
  logic                r_instr_valid, w_valid_nxt;
  logic                r_kill, w_kill_nxt;
  logic                r_imem_req;
  logic                r_halted;

  logic [PC_WIDTH-1:0] w_boff_ext;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_halt_sel;
  logic                w_accept;
  logic                w_consume;

  // imem_req is already low in the first cycle after reset, so the accept
  // gate also filters any stray response left over from before reset.
  assign w_accept   = (r_state == S_REQ) && r_imem_req && bus.imem_valid;
  assign w_consume  = (r_state == S_HOLD) && !bus.flush && !bus.stall;
  assign w_boff_ext = PC_WIDTH'($signed(bus.boffset));

`ifdef FETCH_STAGE_PC_RAS_EN
  localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);

  // Entry 0 is the top of stack; a push shifts everything down so the
  // oldest entry falls off the bottom when the stack is full.
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [RAS_CW-1:0]   r_ras_cnt;
  logic                w_push;
  logic                w_pop;
`else
  logic w_unused_ras;
  assign w_unused_ras = (RAS_DEPTH != 0);
`endif

  always_comb begin
    w_next_pc  = r_pc_out + PC_ONE;
    w_halt_sel = 1'b0;
`ifdef FETCH_STAGE_PC_RAS_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
`endif
    case (bus.pccontrol)
      3'b001: w_next_pc = r_pc_out + w_boff_ext;
      3'b010: w_next_pc = bus.target;
`ifdef FETCH_STAGE_PC_RAS_EN
      3'b011: begin
        w_next_pc = bus.target;
        w_push    = 1'b1;
      end
      3'b100: begin
        if (r_ras_cnt != '0) begin
          w_next_pc = r_ras[0];
          w_pop     = 1'b1;
        end else begin
          w_next_pc = bus.target;
        end
      end
`else
      3'b011: w_next_pc = bus.target;
`endif
      3'b111: w_halt_sel = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pc_out_nxt   = r_pc_out;
    w_redirect_nxt = r_redirect_pc;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_instr_valid;
    w_kill_nxt     = r_kill;
    case (r_state)
      S_REQ: begin
        if (bus.flush) begin
          if (w_accept) begin
            // Response and flush coincide: drop the word and redirect now.
            w_fetch_pc_nxt = bus.target;
            w_kill_nxt     = 1'b0;
          end else begin
            // Address must stay put until the outstanding response returns.
            w_redirect_nxt = bus.target;
            w_kill_nxt     = 1'b1;
          end
        end else if (w_accept) begin
          if (r_kill) begin
            w_fetch_pc_nxt = r_redirect_pc;
            w_kill_nxt     = 1'b0;
          end else begin
            w_instr_nxt  = bus.imem_rdata;
            w_valid_nxt  = 1'b1;
            w_pc_out_nxt = r_fetch_pc;
            w_state_nxt  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.flush) begin
          w_valid_nxt    = 1'b0;
          w_instr_nxt    = NOP_INSTR;
          w_fetch_pc_nxt = bus.target;
          w_state_nxt    = S_REQ;
        end else if (!bus.stall) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          if (w_halt_sel) begin
            w_state_nxt = S_HALT;
          end else begin
            w_fetch_pc_nxt = w_next_pc;
            w_state_nxt    = S_REQ;
          end
        end
      end
      S_HALT: begin
        w_valid_nxt = 1'b0;
        w_instr_nxt = NOP_INSTR;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_pc_out      <= '0;
      r_redirect_pc <= '0;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_kill        <= 1'b0;
      r_imem_req    <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_redirect_pc <= w_redirect_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
      r_kill        <= w_kill_nxt;
      r_imem_req    <= (w_state_nxt == S_REQ);
      r_halted      <= (w_state_nxt == S_HALT);
    end
  end

`ifdef FETCH_STAGE_PC_RAS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_consume && w_push) begin
      for (int i = RAS_DEPTH - 1; i > 0; i--) begin
        r_ras[i] <= r_ras[i-1];
      end
      r_ras[0] <= r_pc_out + PC_ONE;
      if (r_ras_cnt != RAS_CW'(RAS_DEPTH)) begin
        r_ras_cnt <= r_ras_cnt + RAS_CW'(1);
      end
    end else if (w_consume && w_pop) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) begin
        r_ras[i] <= r_ras[i+1];
      end
      r_ras[RAS_DEPTH-1] <= '0;
      r_ras_cnt          <= r_ras_cnt - RAS_CW'(1);
    end
  end
`endif

  assign bus.imem_addr   = r_fetch_pc;
  assign bus.imem_req    = r_imem_req;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_out      = r_pc_out;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with randomized program flow
module tb_fetch_stage;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.PC_WIDTH(8)) bus ();

  fetch_stage #(
    .PC_WIDTH (8),
    .RESET_PC (8'h00),
    .NOP_INSTR(8'h00),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [256];
  int         mem_lat = 1;
  int         resp_cnt = 0;
  logic [7:0] ras_q [$];

  // Memory: answers a request mem_lat cycles after it is seen, one-cycle valid pulse.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      bus.imem_valid = 1'b0;
      resp_cnt = 0;
    end else if (bus.imem_valid) begin
      bus.imem_valid = 1'b0;
      resp_cnt = 0;
    end else if (bus.imem_req) begin
      resp_cnt++;
      if (resp_cnt >= mem_lat) begin
        bus.imem_rdata = mem[bus.imem_addr];
        bus.imem_valid = 1'b1;
        resp_cnt = 0;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // Reference next-PC rule, with the return stack as a plain queue.
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [2:0] pcc,
                                            input logic [7:0] tgt, input logic [7:0] boff);
    int v;
    logic [7:0] pn;
    pn = pc + 8'd1;
    v = int'(pn);
    case (pcc)
      3'd1: v = int'(pc) + int'($signed(boff));
      3'd2: v = int'(tgt);
`ifdef FETCH_STAGE_PC_RAS_EN
      3'd3: begin
        ras_q.push_front(pn);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_back());
        v = int'(tgt);
      end
      3'd4: begin
        if (ras_q.size() > 0) v = int'(ras_q.pop_front());
        else v = int'(tgt);
      end
`else
      3'd3: v = int'(tgt);
`endif
      default: ;
    endcase
    return v[7:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.stall = 1'b1;
    bus.flush = 1'b0;
    bus.pccontrol = 3'd0;
    bus.target = 8'h00;
    bus.boffset = 8'h00;
    ras_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: instr_valid=0 after 40 cycles, expected 1", name);
    end
  endtask

  task automatic consume(input logic [2:0] pcc, input logic [7:0] tgt, input logic [7:0] boff);
    bus.pccontrol = pcc;
    bus.target = tgt;
    bus.boffset = boff;
    bus.stall = 1'b0;
    @(negedge clk);
    bus.stall = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.instr, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_req, bus.imem_addr} !==
        {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_outputs: got instr=%h v=%b pc=%h halted=%b req=%b addr=%h, expected 00 0 00 0 0 00",
               bus.instr, bus.instr_valid, bus.pc_out, bus.halted, bus.imem_req, bus.imem_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h, expected 1 00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    mem_lat = 1;
    wait_valid("basic");
    n_checks++;
    if ({bus.instr, bus.pc_out} !== {8'hA5, 8'h00}) begin
      n_errors++;
      $display("FAIL basic_instr: got instr=%h pc=%h, expected A5 00", bus.instr, bus.pc_out);
    end
    consume(3'b000, 8'h00, 8'h00);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr} !== {1'b1, 8'h01, 1'b0, 8'h00}) begin
      n_errors++;
      $display("FAIL basic_next: got req=%b addr=%h v=%b instr=%h, expected 1 01 0 00",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr);
    end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    mem_lat = 1;
    wait_valid("br0");
    consume(3'b010, 8'h10, 8'h00);
    wait_valid("br1");
    n_checks++;
    if ({bus.pc_out, bus.instr} !== {8'h10, mem[8'h10]}) begin
      n_errors++;
      $display("FAIL jump_pc: got pc=%h instr=%h, expected 10 %h", bus.pc_out, bus.instr, mem[8'h10]);
    end
    consume(3'b001, 8'h00, 8'hFC);
    n_checks++;
    if (bus.imem_addr !== 8'h0C) begin
      n_errors++;
      $display("FAIL branch_back: got addr=%h, expected 0C", bus.imem_addr);
    end
    wait_valid("br2");
    consume(3'b010, 8'hFF, 8'h00);
    wait_valid("br3");
    consume(3'b000, 8'h00, 8'h00);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL pc_wrap: got req=%b addr=%h, expected 1 00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [7:0] s_instr, s_pc;
    do_reset();
    mem_lat = 2;
    wait_valid("stall");
    s_instr = bus.instr;
    s_pc = bus.pc_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.instr, bus.pc_out, bus.instr_valid, bus.imem_req} !== {s_instr, s_pc, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got instr=%h pc=%h v=%b req=%b, expected %h %h 1 0",
                 i, bus.instr, bus.pc_out, bus.instr_valid, bus.imem_req, s_instr, s_pc);
      end
    end
    consume(3'b000, 8'h00, 8'h00);
    n_checks++;
    if ({bus.imem_req, bus.instr_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL stall_release: got req=%b v=%b, expected 1 0", bus.imem_req, bus.instr_valid);
    end
  endtask

  task automatic test_flush_outstanding();
    do_reset();
    mem_lat = 1;
    wait_valid("fl0");
    mem_lat = 6;
    consume(3'b010, 8'h03, 8'h00);
    bus.flush = 1'b1;
    bus.target = 8'h40;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.target = 8'h99;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_addr !== 8'h03) break;
      @(negedge clk);
    end
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 8'h40, 1'b0}) begin
      n_errors++;
      $display("FAIL flush_redirect: got req=%b addr=%h v=%b, expected 1 40 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    mem_lat = 1;
    wait_valid("fl1");
    n_checks++;
    if ({bus.pc_out, bus.instr} !== {8'h40, mem[8'h40]}) begin
      n_errors++;
      $display("FAIL flush_target_fetch: got pc=%h instr=%h, expected 40 %h", bus.pc_out, bus.instr, mem[8'h40]);
    end
  endtask

  task automatic test_ras();
    logic [7:0] exp_ret;
    do_reset();
    mem_lat = 1;
    wait_valid("ras0");
    consume(3'b010, 8'h05, 8'h00);
    wait_valid("ras1");
    consume(3'b011, 8'h20, 8'h00);
    wait_valid("ras2");
    n_checks++;
    if (bus.pc_out !== 8'h20) begin
      n_errors++;
      $display("FAIL call_target: got pc=%h, expected 20", bus.pc_out);
    end
`ifdef FETCH_STAGE_PC_RAS_EN
    exp_ret = 8'h06;
`else
    exp_ret = 8'h21;
`endif
    consume(3'b100, 8'h77, 8'h00);
    n_checks++;
    if (bus.imem_addr !== exp_ret) begin
      n_errors++;
      $display("FAIL return_addr: got addr=%h, expected %h", bus.imem_addr, exp_ret);
    end
  endtask

  task automatic test_random_flow();
    logic [7:0] exp_pc, t, bo;
    logic [2:0] pcc;
    do_reset();
    exp_pc = 8'h00;
    for (int n = 0; n < 80; n++) begin
      mem_lat = $urandom_range(1, 4);
      wait_valid("rand");
      n_checks++;
      if ({bus.pc_out, bus.instr} !== {exp_pc, mem[exp_pc]}) begin
        n_errors++;
        $display("FAIL rand_fetch[%0d]: got pc=%h instr=%h, expected %h %h",
                 n, bus.pc_out, bus.instr, exp_pc, mem[exp_pc]);
      end
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        @(negedge clk);
        n_checks++;
        if ({bus.instr, bus.pc_out, bus.instr_valid, bus.imem_req} !== {mem[exp_pc], exp_pc, 1'b1, 1'b0}) begin
          n_errors++;
          $display("FAIL rand_stall[%0d]: got instr=%h pc=%h v=%b req=%b", n,
                   bus.instr, bus.pc_out, bus.instr_valid, bus.imem_req);
        end
      end
      t = 8'($urandom);
      bo = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.flush = 1'b1;
        bus.target = t;
        bus.pccontrol = 3'($urandom_range(0, 7));
        bus.stall = 1'($urandom);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.stall = 1'b1;
        exp_pc = t;
      end else begin
        pcc = 3'($urandom_range(0, 6));
        exp_pc = model_next(exp_pc, pcc, t, bo);
        consume(pcc, t, bo);
      end
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, exp_pc, 1'b0}) begin
        n_errors++;
        $display("FAIL rand_next[%0d]: got req=%b addr=%h v=%b, expected 1 %h 0",
                 n, bus.imem_req, bus.imem_addr, bus.instr_valid, exp_pc);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (bus.instr_valid === 1'b0) begin
          t = 8'($urandom);
          bus.flush = 1'b1;
          bus.target = t;
          @(negedge clk);
          bus.flush = 1'b0;
          exp_pc = t;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 1;
    wait_valid("rm0");
    mem_lat = 4;
    consume(3'b010, 8'h30, 8'h00);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr, bus.pc_out} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got v=%b req=%b addr=%h pc=%h, expected 0 0 00 00",
               bus.instr_valid, bus.imem_req, bus.imem_addr, bus.pc_out);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_lat = 1;
    wait_valid("rm1");
    n_checks++;
    if ({bus.pc_out, bus.instr} !== {8'h00, mem[8'h00]}) begin
      n_errors++;
      $display("FAIL reset_mid_restart: got pc=%h instr=%h, expected 00 %h", bus.pc_out, bus.instr, mem[8'h00]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    mem_lat = 1;
    wait_valid("halt");
    consume(3'b111, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({bus.halted, bus.imem_req, bus.instr_valid} !== 3'b100) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: got halted=%b req=%b v=%b, expected 1 0 0",
                 i, bus.halted, bus.imem_req, bus.instr_valid);
      end
      bus.flush = 1'(i % 2);
      bus.target = 8'($urandom);
      bus.stall = 1'($urandom);
      @(negedge clk);
    end
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.halted !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_reset: got halted=%b, expected 0", bus.halted);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.halted} !== {1'b1, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL halt_restart: got req=%b addr=%h halted=%b, expected 1 00 0",
               bus.imem_req, bus.imem_addr, bus.halted);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    reset_n = 1'b0;
    bus.stall = 1'b1;
    bus.flush = 1'b0;
    bus.pccontrol = 3'd0;
    bus.target = 8'h00;
    bus.boffset = 8'h00;
    bus.imem_rdata = 8'h00;
    test_reset();
    test_basic_fetch();
    test_branch_wrap();
    test_stall();
    test_flush_outstanding();
    test_ras();
    test_random_flow();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
